// File: rtl/pixel_buf_pkg.sv
// Shared constants, types and helpers for the ping-pong pixel buffer.
// Provides default geometry, bank select type and the lane mask builder.
package pixel_buf_pkg;

    localparam int DATA_W_D = 16;
    localparam int CH_D     = 3;
    localparam int ADDR_W_D = 10;
    localparam int DEPTH_D  = 1024;
    localparam int PIX_W    = CH_D * DATA_W_D;

    typedef logic bank_sel_t;

    // One-hot lane mask, all zero when ch is not a valid lane.
    function automatic logic [3:0] lane_sel(
        input int unsigned ch,
        input int unsigned n
    );
        logic [3:0] m;
        m = '0;
        if (ch < n && ch < 4)
            m[ch[1:0]] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/pixel_bank.sv
// One bank of DEPTH pixels x CH lanes, per-lane write enables and a
// registered packed read port. PIXEL_PARITY_EN adds per-lane parity + rd_perr.
module pixel_bank
    import pixel_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int CH     = CH_D,
    parameter int ADDR_W = ADDR_W_D,
    parameter int DEPTH  = DEPTH_D
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH-1:0]        wr_mask,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
`ifdef PIXEL_PARITY_EN
    output logic [CH-1:0]        rd_perr,
`endif
    output logic [CH*DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH][CH];
    logic              rd_in;

    assign rd_in = 32'(rd_addr) < DEPTH;

    // The top only raises mask bits for in-range addresses.
    always_ff @(posedge clk) begin
        for (int k = 0; k < CH; k++)
            if (wr_mask[k])
                mem[wr_addr][k] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            for (int k = 0; k < CH; k++)
                rd_data[k*DATA_W +: DATA_W] <=
                    rd_in ? mem[rd_addr][k] : '0;
        end
    end

`ifdef PIXEL_PARITY_EN
    logic par [DEPTH][CH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < CH; k++)
            if (wr_mask[k])
                par[wr_addr][k] <= ^wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_perr <= '0;
        end else if (rd_en) begin
            for (int k = 0; k < CH; k++)
                rd_perr[k] <= rd_in &&
                    ((^mem[rd_addr][k]) != par[rd_addr][k]);
        end
    end
`endif

endmodule

// File: rtl/local_mem_pixel_pp.sv
// Double-buffered multi-channel pixel store: lane-wise writes into one bank,
// packed pixel reads from the other, banks swapped by wr_last/rd_last.
// Ports: wr_* write side, rd_* read side, full_cnt, sticky err_addr.
// Option macro PIXEL_PARITY_EN adds per-lane parity and rd_perr[CH].
module local_mem_pixel_pp
    import pixel_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int CH     = CH_D,
    parameter int CH_W   = 2,
    parameter int ADDR_W = ADDR_W_D,
    parameter int DEPTH  = DEPTH_D
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 wr_last,
    output logic                 wr_ready,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic                 rd_last,
    output logic                 rd_ready,
    output logic [CH*DATA_W-1:0] rd_data,
    output logic                 rd_valid,
    output logic [1:0]           full_cnt,
`ifdef PIXEL_PARITY_EN
    output logic [CH-1:0]        rd_perr,
`endif
    output logic                 err_addr
);

    bank_sel_t   wr_bank;
    bank_sel_t   rd_bank;
    bank_sel_t   rd_sel;
    logic [1:0]  full;
    logic [1:0]  full_nxt;
    logic [3:0]  sel4;
    logic [CH-1:0] mask;
    logic        wr_acc;
    logic        rd_acc;
    logic        wr_ok;
    logic        rd_ok;
    logic        wr_ch_ok;
    logic        wr_addr_ok;

    logic [CH*DATA_W-1:0] bank_data [2];
`ifdef PIXEL_PARITY_EN
    logic [CH-1:0]        bank_perr [2];
`endif

    assign wr_ready = !full[wr_bank];
    assign rd_ready = full[rd_bank];
    assign full_cnt = {1'b0, full[0]} + {1'b0, full[1]};

    assign wr_acc = wr_en && wr_ready;
    assign rd_acc = rd_en && rd_ready;

    // sel4 is zero exactly when wr_ch is not a valid lane.
    assign sel4       = lane_sel(32'(wr_ch), CH);
    assign wr_ch_ok   = |sel4;
    assign wr_addr_ok = 32'(wr_addr) < DEPTH;
    assign wr_ok      = wr_ch_ok && wr_addr_ok;
    assign rd_ok      = 32'(rd_addr) < DEPTH;

    always_comb begin
        mask = '0;
        for (int k = 0; k < CH; k++)
            mask[k] = sel4[k] && wr_acc && wr_ok;
    end

    // Write and read banks always differ when both last flags fire.
    always_comb begin
        full_nxt = full;
        if (wr_acc && wr_last)
            full_nxt[wr_bank] = 1'b1;
        if (rd_acc && rd_last)
            full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            rd_sel   <= 1'b0;
            rd_valid <= 1'b0;
            err_addr <= 1'b0;
        end else begin
            full     <= full_nxt;
            rd_valid <= rd_acc;
            if (wr_acc && wr_last)
                wr_bank <= !wr_bank;
            if (rd_acc)
                rd_sel <= rd_bank;
            if (rd_acc && rd_last)
                rd_bank <= !rd_bank;
            if ((wr_acc && !wr_ok) || (rd_acc && !rd_ok))
                err_addr <= 1'b1;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pixel_bank #(
            .DATA_W (DATA_W),
            .CH     (CH),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_mask (wr_bank == b[0] ? mask : '0),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_en   (rd_acc && (rd_bank == b[0])),
            .rd_addr (rd_addr),
`ifdef PIXEL_PARITY_EN
            .rd_perr (bank_perr[b]),
`endif
            .rd_data (bank_data[b])
        );
    end

    // Each bank holds its last read, so the registered select holds rd_data.
    assign rd_data = bank_data[rd_sel];
`ifdef PIXEL_PARITY_EN
    assign rd_perr = bank_perr[rd_sel];
`endif

endmodule

// File: tb/tb_local_mem_pixel_pp.sv
// Directed self-checking bench for local_mem_pixel_pp (DEPTH=1000).
// Immediate assertions at each check point, one summary line at the end.
module tb_local_mem_pixel_pp;

    localparam int DATA_W = 16;
    localparam int CH     = 3;
    localparam int CH_W   = 2;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1000;

    logic                 clk;
    logic                 rst;
    logic                 wr_en;
    logic [CH_W-1:0]      wr_ch;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 wr_last;
    logic                 wr_ready;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_last;
    logic                 rd_ready;
    logic [CH*DATA_W-1:0] rd_data;
    logic                 rd_valid;
    logic [1:0]           full_cnt;
`ifdef PIXEL_PARITY_EN
    logic [CH-1:0]        rd_perr;
`endif
    logic                 err_addr;

    int n_chk;
    int n_fail;

    local_mem_pixel_pp #(
        .DATA_W (DATA_W),
        .CH     (CH),
        .CH_W   (CH_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_last  (wr_last),
        .wr_ready (wr_ready),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_last  (rd_last),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full_cnt (full_cnt),
`ifdef PIXEL_PARITY_EN
        .rd_perr  (rd_perr),
`endif
        .err_addr (err_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] val(int b, int p, int k);
        return {4'(b + 1), 4'(p), 4'h0, 4'(k)};
    endfunction

    function automatic logic [47:0] pix(int b, int p);
        return {val(b, p, 2), val(b, p, 1), val(b, p, 0)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input int ch, input int addr,
                      input logic [15:0] d, input logic last);
        wr_en   = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_addr = ADDR_W'(addr);
        wr_data = d;
        wr_last = last;
        step();
        wr_en   = 1'b0;
        wr_last = 1'b0;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        wr_en   = 0;
        wr_ch   = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_last = 0;
        rd_en   = 0;
        rd_addr = '0;
        rd_last = 0;
        rst     = 1'b1;
        #1 rst  = 1'b0;
        #1;
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_rd_ready", 64'(rd_ready), 64'd0);
        chk("rst_full_cnt", 64'(full_cnt), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_err", 64'(err_addr), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        wr(0, 5, 16'h0A0A, 1'b0);
        wr(1, 5, 16'h0B0B, 1'b0);
        wr(2, 5, 16'h0C0C, 1'b1);
        chk("p5_full_cnt", 64'(full_cnt), 64'd1);
        chk("p5_rd_ready", 64'(rd_ready), 64'd1);
        chk("p5_wr_ready", 64'(wr_ready), 64'd1);

        rd_en = 1; rd_addr = 5; rd_last = 1;
        step();
        rd_en = 0; rd_last = 0;
        chk("p5_rd_valid", 64'(rd_valid), 64'd1);
        chk("p5_rd_data", 64'(rd_data), 64'h0C0C_0B0B_0A0A);
        chk("p5_drain_cnt", 64'(full_cnt), 64'd0);
        step();
        chk("idle_rd_valid", 64'(rd_valid), 64'd0);
        chk("idle_rd_hold", 64'(rd_data), 64'h0C0C_0B0B_0A0A);

        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 3; k++)
                wr(k, p, val(1, p, k), p == 3 && k == 2);
        chk("b1_full_cnt", 64'(full_cnt), 64'd1);
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 3; k++)
                wr(k, p, val(0, p, k), p == 3 && k == 2);
        chk("both_full_cnt", 64'(full_cnt), 64'd2);
        chk("both_wr_ready", 64'(wr_ready), 64'd0);
        wr(0, 0, 16'hFFFF, 1'b1);
        chk("ign_full_cnt", 64'(full_cnt), 64'd2);

        for (int i = 0; i < 4; i++) begin
            rd_en = 1; rd_addr = ADDR_W'(i); rd_last = (i == 3);
            step();
            chk($sformatf("burst_valid%0d", i), 64'(rd_valid), 64'd1);
            chk($sformatf("burst_data%0d", i), 64'(rd_data),
                64'(pix(1, i)));
        end
        rd_en = 0; rd_last = 0;
        chk("burst_full_cnt", 64'(full_cnt), 64'd1);
        chk("burst_wr_ready", 64'(wr_ready), 64'd1);
        chk("burst_rd_ready", 64'(rd_ready), 64'd1);

        rd_en = 1; rd_addr = 2; rd_last = 1;
        wr(0, 7, 16'h7777, 1'b1);
        rd_en = 0; rd_last = 0;
        chk("swap_full_cnt", 64'(full_cnt), 64'd1);
        chk("swap_rd_ready", 64'(rd_ready), 64'd1);
        chk("swap_wr_ready", 64'(wr_ready), 64'd1);
        chk("swap_rd_data", 64'(rd_data), 64'(pix(0, 2)));

        wr(3, 0, 16'hFFFF, 1'b0);
        chk("err_ch", 64'(err_addr), 64'd1);
        chk("err_ch_cnt", 64'(full_cnt), 64'd1);
        rd_en = 1; rd_addr = 10'd1023;
        step();
        rd_en = 0;
        chk("err_rd_valid", 64'(rd_valid), 64'd1);
        chk("err_rd_data", 64'(rd_data), 64'd0);
        step();
        chk("err_sticky", 64'(err_addr), 64'd1);
        chk("err_full_cnt", 64'(full_cnt), 64'd1);

        wr(0, 0, 16'h1234, 1'b0);
        rd_en = 1; rd_addr = 0;
        wr(1, 0, 16'h5678, 1'b0);
        rd_en = 0;
        chk("pre_rst_valid", 64'(rd_valid), 64'd1);
        chk("pre_rst_data", 64'(rd_data), 64'(pix(1, 0)));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("mid_rst_rd_ready", 64'(rd_ready), 64'd0);
        chk("mid_rst_full_cnt", 64'(full_cnt), 64'd0);
        chk("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("mid_rst_err", 64'(err_addr), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
